// File: rtl/wb_stage.sv
// Y86-64 writeback stage: W pipeline register, 15-entry register file, status/halt and retire counter.
// Optional `WB_BYPASS_EN: read ports return the pending W-stage write data in the same cycle.
module wb_stage #(
   parameter logic [63:0] RF_INIT = 64'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic [2:0]  m_stat,
   input  logic [3:0]  m_icode,
   input  logic [63:0] m_valE,
   input  logic [63:0] m_valM,
   input  logic [3:0]  m_dstE,
   input  logic [3:0]  m_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic [63:0] rvalA,
   output logic [63:0] rvalB,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [2:0]  W_stat,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] retired
);

   localparam logic [2:0] STAT_AOK   = 3'd1;
   localparam logic [3:0] ICODE_NOP  = 4'h1;
   localparam logic [3:0] REG_NONE   = 4'hF;

   logic        w_valid_q, w_valid_d;
   logic [2:0]  w_stat_q,  w_stat_d;
   logic [3:0]  w_icode_q, w_icode_d;
   logic [63:0] w_val_e_q, w_val_e_d;
   logic [63:0] w_val_m_q, w_val_m_d;
   logic [3:0]  w_dst_e_q, w_dst_e_d;
   logic [3:0]  w_dst_m_q, w_dst_m_d;
   logic        w_new_q,   w_new_d;
   logic        halted_q,  halted_d;
   logic [63:0] retired_q, retired_d;

   logic [63:0] rf_q [15];

   logic        w_aok;
   logic        wr_e_en;
   logic        wr_m_en;

   assign w_aok   = (w_stat_q == STAT_AOK);
   assign wr_e_en = w_aok && (w_dst_e_q != REG_NONE);
   assign wr_m_en = w_aok && (w_dst_m_q != REG_NONE);

   // W register next state: halt freeze and stall both hold; stall beats bubble.
   always_comb begin
      w_valid_d = w_valid_q;
      w_stat_d  = w_stat_q;
      w_icode_d = w_icode_q;
      w_val_e_d = w_val_e_q;
      w_val_m_d = w_val_m_q;
      w_dst_e_d = w_dst_e_q;
      w_dst_m_d = w_dst_m_q;
      w_new_d   = 1'b0;
      if (halted_q || W_stall) begin
         w_new_d = 1'b0;
      end else if (W_bubble) begin
         w_valid_d = 1'b0;
         w_stat_d  = STAT_AOK;
         w_icode_d = ICODE_NOP;
         w_val_e_d = 64'd0;
         w_val_m_d = 64'd0;
         w_dst_e_d = REG_NONE;
         w_dst_m_d = REG_NONE;
      end else begin
         w_valid_d = m_valid;
         w_stat_d  = m_stat;
         w_icode_d = m_icode;
         w_val_e_d = m_valE;
         w_val_m_d = m_valM;
         w_dst_e_d = m_dstE;
         w_dst_m_d = m_dstM;
         w_new_d   = 1'b1;
      end
   end

   always_comb begin
      halted_d  = halted_q || !w_aok;
      retired_d = retired_q;
      if (w_new_q && w_valid_q && w_aok) begin
         retired_d = retired_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_valid_q <= 1'b0;
         w_stat_q  <= STAT_AOK;
         w_icode_q <= ICODE_NOP;
         w_val_e_q <= 64'd0;
         w_val_m_q <= 64'd0;
         w_dst_e_q <= REG_NONE;
         w_dst_m_q <= REG_NONE;
         w_new_q   <= 1'b0;
         halted_q  <= 1'b0;
         retired_q <= 64'd0;
      end else begin
         w_valid_q <= w_valid_d;
         w_stat_q  <= w_stat_d;
         w_icode_q <= w_icode_d;
         w_val_e_q <= w_val_e_d;
         w_val_m_q <= w_val_m_d;
         w_dst_e_q <= w_dst_e_d;
         w_dst_m_q <= w_dst_m_d;
         w_new_q   <= w_new_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   // valM write is issued last so it wins when both ports target one register (popq %rsp).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) begin
            rf_q[i] <= RF_INIT;
         end
      end else begin
         if (wr_e_en) begin
            rf_q[w_dst_e_q] <= w_val_e_q;
         end
         if (wr_m_en) begin
            rf_q[w_dst_m_q] <= w_val_m_q;
         end
      end
   end

   always_comb begin
      rvalA = 64'd0;
      rvalB = 64'd0;
      if (srcA != REG_NONE) begin
         rvalA = rf_q[srcA];
      end
      if (srcB != REG_NONE) begin
         rvalB = rf_q[srcB];
      end
`ifdef WB_BYPASS_EN
      if (wr_m_en && (srcA == w_dst_m_q)) begin
         rvalA = w_val_m_q;
      end else if (wr_e_en && (srcA == w_dst_e_q)) begin
         rvalA = w_val_e_q;
      end
      if (wr_m_en && (srcB == w_dst_m_q)) begin
         rvalB = w_val_m_q;
      end else if (wr_e_en && (srcB == w_dst_e_q)) begin
         rvalB = w_val_e_q;
      end
`else
      // No bypass: the decode stage forwards from the W_* outputs instead.
`endif
   end

   assign W_icode = w_icode_q;
   assign W_valE  = w_val_e_q;
   assign W_valM  = w_val_m_q;
   assign W_dstE  = w_dst_e_q;
   assign W_dstM  = w_dst_m_q;
   assign W_stat  = w_stat_q;
   assign stat    = w_stat_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; works with or without WB_BYPASS_EN defined.
module tb_wb_stage;

   localparam logic [63:0] RF_INIT_TB = 64'hA5A5_0000_0000_5A5A;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        m_valid;
   logic [2:0]  m_stat;
   logic [3:0]  m_icode;
   logic [63:0] m_valE;
   logic [63:0] m_valM;
   logic [3:0]  m_dstE;
   logic [3:0]  m_dstM;
   logic        W_stall;
   logic        W_bubble;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [63:0] rvalA;
   logic [63:0] rvalB;
   logic [3:0]  W_icode;
   logic [63:0] W_valE;
   logic [63:0] W_valM;
   logic [3:0]  W_dstE;
   logic [3:0]  W_dstM;
   logic [2:0]  W_stat;
   logic [2:0]  stat;
   logic        halted;
   logic [63:0] retired;

   int tests_run = 0;
   int failed    = 0;

   wb_stage #(.RF_INIT(RF_INIT_TB)) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
      .m_valE(m_valE), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble),
      .srcA(srcA), .srcB(srcB), .rvalA(rvalA), .rvalB(rvalB),
      .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .W_stat(W_stat),
      .stat(stat), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [2:0] st, input logic [3:0] ic,
                            input logic [63:0] ve, input logic [63:0] vm,
                            input logic [3:0] de, input logic [3:0] dm);
      m_valid = 1'b1;
      m_stat  = st;
      m_icode = ic;
      m_valE  = ve;
      m_valM  = vm;
      m_dstE  = de;
      m_dstM  = dm;
   endtask

   task automatic set_idle();
      m_valid  = 1'b0;
      m_stat   = 3'd1;
      m_icode  = 4'h1;
      m_valE   = 64'd0;
      m_valM   = 64'd0;
      m_dstE   = 4'hF;
      m_dstM   = 4'hF;
      W_stall  = 1'b0;
      W_bubble = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] exp_a, exp_b;
      srcA = 4'h0;
      srcB = 4'h0;
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests_run++;
      if (W_icode !== 4'h1 || W_dstE !== 4'hF || W_dstM !== 4'hF || W_valE !== 64'd0 || W_valM !== 64'd0 || W_stat !== 3'd1) begin
         failed++;
         $display("FAIL reset_wreg icode=%h dstE=%h dstM=%h valE=%h valM=%h stat=%0d exp 1/F/F/0/0/1", W_icode, W_dstE, W_dstM, W_valE, W_valM, W_stat);
      end
      tests_run++;
      if (stat !== 3'd1 || halted !== 1'b0 || retired !== 64'd0) begin
         failed++;
         $display("FAIL reset_status stat=%0d halted=%b retired=%0d exp 1/0/0", stat, halted, retired);
      end
      for (int i = 0; i < 16; i++) begin
         srcA = 4'(i);
         srcB = 4'(15 - i);
         #1;
         exp_a = (i == 15) ? 64'd0 : RF_INIT_TB;
         exp_b = (i == 0) ? 64'd0 : RF_INIT_TB;
         tests_run++;
         if (rvalA !== exp_a || rvalB !== exp_b) begin
            failed++;
            $display("FAIL reset_read srcA=%h rvalA=%h exp %h srcB=%h rvalB=%h exp %h", srcA, rvalA, exp_a, srcB, rvalB, exp_b);
         end
      end
      tick();
   endtask

   task automatic test_irmovq();
      logic [63:0] exp_byp;
      srcA = 4'h3;
      set_instr(3'd1, 4'h3, 64'h1234, 64'd0, 4'h3, 4'hF);
      tick();
      set_idle();
      #1;
      exp_byp = BYP ? 64'h1234 : RF_INIT_TB;
      tests_run++;
      if (rvalA !== exp_byp) begin
         failed++;
         $display("FAIL irmovq_same_cycle rvalA=%h exp %h", rvalA, exp_byp);
      end
      tests_run++;
      if (W_dstE !== 4'h3 || W_valE !== 64'h1234 || retired !== 64'd0) begin
         failed++;
         $display("FAIL irmovq_wreg dstE=%h valE=%h retired=%0d exp 3/1234/0", W_dstE, W_valE, retired);
      end
      tick();
      tests_run++;
      if (rvalA !== 64'h1234 || retired !== 64'd1) begin
         failed++;
         $display("FAIL irmovq_commit rvalA=%h retired=%0d exp 1234/1", rvalA, retired);
      end
   endtask

   task automatic test_popq();
      logic [63:0] exp_byp;
      srcB = 4'h4;
      set_instr(3'd1, 4'hB, 64'h100, 64'hBEEF, 4'h4, 4'h4);
      tick();
      set_idle();
      #1;
      exp_byp = BYP ? 64'hBEEF : RF_INIT_TB;
      tests_run++;
      if (rvalB !== exp_byp) begin
         failed++;
         $display("FAIL popq_same_cycle rvalB=%h exp %h", rvalB, exp_byp);
      end
      tick();
      tests_run++;
      if (rvalB !== 64'hBEEF || retired !== 64'd2) begin
         failed++;
         $display("FAIL popq_commit rvalB=%h retired=%0d exp beef/2", rvalB, retired);
      end
   endtask

   task automatic test_stall();
      srcA = 4'h6;
      srcB = 4'h7;
      set_instr(3'd1, 4'h6, 64'h66, 64'd0, 4'h6, 4'hF);
      tick();
      set_instr(3'd1, 4'h6, 64'h77, 64'd0, 4'h7, 4'hF);
      W_stall = 1'b1;
      tick();
      tick();
      tick();
      tests_run++;
      if (W_dstE !== 4'h6 || W_valE !== 64'h66 || W_icode !== 4'h6) begin
         failed++;
         $display("FAIL stall_hold dstE=%h valE=%h icode=%h exp 6/66/6", W_dstE, W_valE, W_icode);
      end
      tests_run++;
      if (rvalA !== 64'h66 || rvalB !== RF_INIT_TB) begin
         failed++;
         $display("FAIL stall_rf rvalA=%h rvalB=%h exp 66/%h", rvalA, rvalB, RF_INIT_TB);
      end
      tests_run++;
      if (retired !== 64'd3) begin
         failed++;
         $display("FAIL stall_retire_once retired=%0d exp 3", retired);
      end
      W_bubble = 1'b1;
      tick();
      tests_run++;
      if (W_dstE !== 4'h6 || W_valE !== 64'h66) begin
         failed++;
         $display("FAIL stall_beats_bubble dstE=%h valE=%h exp 6/66", W_dstE, W_valE);
      end
      W_stall = 1'b0;
      tick();
      tests_run++;
      if (W_icode !== 4'h1 || W_dstE !== 4'hF || W_valE !== 64'd0 || retired !== 64'd3) begin
         failed++;
         $display("FAIL bubble_load icode=%h dstE=%h valE=%h retired=%0d exp 1/F/0/3", W_icode, W_dstE, W_valE, retired);
      end
      set_idle();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_byp;
      srcA = 4'hA;
      srcB = 4'hB;
      set_instr(3'd1, 4'h6, 64'hA, 64'd0, 4'hA, 4'hF);
      tick();
      set_instr(3'd1, 4'h5, 64'd0, 64'hB, 4'hF, 4'hB);
      tick();
      set_idle();
      #1;
      exp_byp = BYP ? 64'hB : RF_INIT_TB;
      tests_run++;
      if (rvalA !== 64'hA || rvalB !== exp_byp) begin
         failed++;
         $display("FAIL b2b_first rvalA=%h exp a rvalB=%h exp %h", rvalA, rvalB, exp_byp);
      end
      tick();
      tests_run++;
      if (rvalB !== 64'hB || retired !== 64'd5) begin
         failed++;
         $display("FAIL b2b_second rvalB=%h retired=%0d exp b/5", rvalB, retired);
      end
   endtask

   task automatic test_halt();
      srcA = 4'h5;
      srcB = 4'h8;
      set_instr(3'd2, 4'h0, 64'h55, 64'd0, 4'h5, 4'hF);
      tick();
      tests_run++;
      if (stat !== 3'd2 || halted !== 1'b0 || rvalA !== RF_INIT_TB) begin
         failed++;
         $display("FAIL halt_enter stat=%0d halted=%b rvalA=%h exp 2/0/%h", stat, halted, rvalA, RF_INIT_TB);
      end
      tick();
      tests_run++;
      if (halted !== 1'b1 || stat !== 3'd2 || rvalA !== RF_INIT_TB) begin
         failed++;
         $display("FAIL halt_set halted=%b stat=%0d rvalA=%h exp 1/2/%h", halted, stat, rvalA, RF_INIT_TB);
      end
      set_instr(3'd1, 4'h3, 64'h88, 64'd0, 4'h8, 4'hF);
      tick();
      W_bubble = 1'b1;
      tick();
      tick();
      tests_run++;
      if (W_stat !== 3'd2 || W_dstE !== 4'h5 || W_valE !== 64'h55 || halted !== 1'b1) begin
         failed++;
         $display("FAIL halt_freeze stat=%0d dstE=%h valE=%h halted=%b exp 2/5/55/1", W_stat, W_dstE, W_valE, halted);
      end
      tests_run++;
      if (rvalB !== RF_INIT_TB || retired !== 64'd5) begin
         failed++;
         $display("FAIL halt_no_effect rvalB=%h retired=%0d exp %h/5", rvalB, retired, RF_INIT_TB);
      end
      srcA = 4'h5;
      srcB = 4'h3;
      do_reset();
      tests_run++;
      if (halted !== 1'b0 || stat !== 3'd1 || retired !== 64'd0 || W_dstE !== 4'hF) begin
         failed++;
         $display("FAIL halt_reset halted=%b stat=%0d retired=%0d dstE=%h exp 0/1/0/F", halted, stat, retired, W_dstE);
      end
      tests_run++;
      if (rvalA !== RF_INIT_TB || rvalB !== RF_INIT_TB) begin
         failed++;
         $display("FAIL halt_reset_rf rvalA=%h rvalB=%h exp %h", rvalA, rvalB, RF_INIT_TB);
      end
   endtask

   task automatic test_wrap();
      srcA = 4'h2;
      set_instr(3'd1, 4'h3, 64'h22, 64'd0, 4'h2, 4'hF);
      force dut.retired_q = '1;
      #1;
      release dut.retired_q;
      tick();
      set_idle();
      tests_run++;
      if (retired !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failed++;
         $display("FAIL wrap_preload retired=%h exp ffffffffffffffff", retired);
      end
      tick();
      tests_run++;
      if (retired !== 64'd0 || rvalA !== 64'h22) begin
         failed++;
         $display("FAIL wrap_commit retired=%h rvalA=%h exp 0/22", retired, rvalA);
      end
   endtask

   task automatic test_mid_reset();
      srcA = 4'h9;
      srcB = 4'h2;
      set_instr(3'd1, 4'h3, 64'h99, 64'd0, 4'h9, 4'hF);
      tick();
      tests_run++;
      if (W_dstE !== 4'h9 || W_valE !== 64'h99) begin
         failed++;
         $display("FAIL midrst_capture dstE=%h valE=%h exp 9/99", W_dstE, W_valE);
      end
      do_reset();
      tests_run++;
      if (W_icode !== 4'h1 || W_dstE !== 4'hF || W_valE !== 64'd0 || retired !== 64'd0) begin
         failed++;
         $display("FAIL midrst_bubble icode=%h dstE=%h valE=%h retired=%0d exp 1/F/0/0", W_icode, W_dstE, W_valE, retired);
      end
      tests_run++;
      if (rvalA !== RF_INIT_TB || rvalB !== RF_INIT_TB) begin
         failed++;
         $display("FAIL midrst_rf rvalA=%h rvalB=%h exp %h", rvalA, rvalB, RF_INIT_TB);
      end
      tick();
      tests_run++;
      if (rvalA !== RF_INIT_TB || retired !== 64'd0 || W_stat !== 3'd1) begin
         failed++;
         $display("FAIL midrst_after rvalA=%h retired=%0d stat=%0d exp %h/0/1", rvalA, retired, W_stat, RF_INIT_TB);
      end
   endtask

   initial begin
      rst = 1'b1;
      srcA = 4'h0;
      srcB = 4'h0;
      set_idle();
      test_reset();
      test_irmovq();
      test_popq();
      test_stall();
      test_back_to_back();
      test_halt();
      test_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the Y86-64 pipeline: W pipeline register plus the architectural register file. It sits directly downstream of the memory stage and captures that stage's result (`valE`, `valM`, destinations, status) on each clock. It commits that result to the 15-entry register file one cycle later. It serves the decode stage's two combinational read ports and drives the processor status and halt indication.

## Interface
Parameters:
- `RF_INIT` (default 0): reset value loaded into every register-file entry.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m_valid`  in  1  memory stage holds a real instruction (0 = bubble).
- `m_stat`  in  3  memory-stage status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `m_icode`  in  4  instruction code.
- `m_valE`  in  64  ALU result.
- `m_valM`  in  64  memory read data.
- `m_dstE`  in  4  destination register for valE; 4'hF = none.
- `m_dstM`  in  4  destination register for valM; 4'hF = none.
- `W_stall`  in  1  hold the W register.
- `W_bubble`  in  1  load a bubble into the W register.
- `srcA`  in  4  decode read address A.
- `srcB`  in  4  decode read address B.
- `rvalA`  out  64  register file read data A; 0 when `srcA`=4'hF.
- `rvalB`  out  64  register file read data B; 0 when `srcB`=4'hF.
- `W_icode`, `W_valE`, `W_valM`, `W_dstE`, `W_dstM`, `W_stat`  out  4/64/64/4/4/3  W register contents, for forwarding.
- `stat`  out  3  processor status (= `W_stat`).
- `halted`  out  1  sticky; set once `W_stat` != AOK.
- `retired`  out  64  count of instructions committed with AOK.

## Operation
- Bubble value: valid=0, icode=4'h1 (nop), valE=valM=0, dstE=dstM=4'hF, stat=AOK.
- W register update priority on each edge:
  - `rst`: load bubble.
  - `halted` or `W_stall`: hold.
  - `W_bubble`: load bubble.
  - otherwise: capture the `m_*` inputs.
- If `W_stall` and `W_bubble` are both high, stall wins.
- Internal flag `w_new`:
  - Set on any edge where the W register captured `m_*`.
  - Cleared otherwise (including on a hold or a bubble load).
  - Reset 0.
- Register file write, when `W_stat`==AOK and not `rst`:
  - `W_dstE`!=F: `rf[W_dstE]` <= `W_valE`.
  - `W_dstM`!=F: `rf[W_dstM]` <= `W_valM`.
  - If `W_dstE`==`W_dstM`!=F, `W_valM` wins (popq %rsp semantics).
  - Writes repeat harmlessly while W is stalled.
- Status:
  - `W_stat` != AOK: no register writes.
  - `halted` sets on the following edge and stays set until `rst`.
  - Once `halted` is set, the W register freezes regardless of `W_stall`/`W_bubble`.
- `retired`:
  - Increments by 1 on an edge where `w_new` && `W_valid` && `W_stat`==AOK.
  - 64-bit, wraps from all-ones to 0.
- Reads are combinational from the register file. Entry 4'hF is not storage and always reads 0.

## Timing
- Reset values (after the first `rst` edge):
  - W register = bubble; all `W_*` outputs at bubble values.
  - `stat` = 1 (AOK).
  - `halted` = 0, `retired` = 0.
  - All 15 register-file entries = `RF_INIT`.
- Latency:
  - `m_*` captured at edge N.
  - Register-file entry updated at edge N+1.
  - Visible on `rvalA`/`rvalB` from edge N+1 onward; with bypass, during the cycle between N and N+1 (see Configuration).
- `rst` mid-operation overrides everything on that edge: in-flight W contents are discarded, and no write, count or halt occurs.
- `halted` asserts exactly one cycle after a non-AOK status enters W.
- The faulting instruction never writes the register file and is never counted.

## Configuration
- `WB_BYPASS_EN` defined:
  - A read whose address matches a pending write (`W_stat`==AOK, address != F) returns that pending data in the same cycle.
  - valM has priority over valE.
  - The decode stage needs no W-stage forwarding path.
- Not defined:
  - Reads return pre-write contents during the write cycle.
  - The decode stage must forward from the `W_*` outputs.

## Test plan
- Reset, then read all srcA/srcB 0..F -> `RF_INIT` for 0..E, 0 for F; `stat`=1, `halted`=0, `retired`=0.
- irmovq-like: `m_valid`=1, `m_stat`=1, `m_dstE`=3, `m_valE`=0x1234 at edge N -> `rf[3]`=0x1234 after edge N+1, `retired`=1. The same-cycle read of `srcA`=3 between N and N+1 returns 0x1234 only with `WB_BYPASS_EN`.
- popq %rsp: `m_dstE`=`m_dstM`=4, `m_valE`=0x100, `m_valM`=0xBEEF -> `rf[4`]=0xBEEF.
- `W_stall` held for 3 cycles with valid AOK in W -> W holds its contents, the register value is unchanged after a rewrite, and `retired` increments exactly once. `W_stall`+`W_bubble` together -> hold.
- `m_stat`=2 (HLT) with `m_dstE`=5 -> `rf[5]` unchanged, `stat`=2, `halted`=1 next cycle. Later `m_*` changes are ignored, and `rst` clears everything.
- Preload `retired` to all-ones (force), then commit one instruction -> `retired`=0. `rst` asserted mid-stream -> bubble values, no write on that edge.
